// File: rtl/bcla_pkg.sv
// Shared types and the 14-bit block carry look-ahead adder core for the BCLA pipe stage.
// The perf counter width here is only used when BCLA_PIPE_PERF_CNT_EN is defined.
package bcla_pkg;

    localparam int BCLA_W     = 14;
    localparam int PERF_CNT_W = 16;
    localparam int BLK_W      = 4;

    typedef logic [BCLA_W-1:0] operand_t;
    typedef logic [BCLA_W:0]   sum_t;

    typedef struct packed {
        operand_t x;
        operand_t y;
        logic     cin;
    } op_pair_t;

    // Blocks of BLK_W bits; each block's carry-out comes from its group G/P, not the ripple.
    function automatic sum_t bcla14_add(input operand_t x, input operand_t y, input logic cin);
        logic [BCLA_W-1:0] g;
        logic [BCLA_W-1:0] p;
        logic [BCLA_W:0]   c;
        logic              bg;
        logic              bp;
        logic              cb;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        bg   = 1'b0;
        bp   = 1'b1;
        cb   = cin;
        for (int i = 0; i < BCLA_W; i++) begin
            if (i % BLK_W == 0) begin
                bg = 1'b0;
                bp = 1'b1;
                cb = c[i];
            end
            c[i+1] = g[i] | (p[i] & c[i]);
            bg     = g[i] | (p[i] & bg);
            bp     = bp & p[i];
            if ((i % BLK_W == BLK_W - 1) || (i == BCLA_W - 1)) begin
                c[i+1] = bg | (bp & cb);
            end
        end
        return {c[BCLA_W], p ^ c[BCLA_W-1:0]};
    endfunction

endpackage

// File: rtl/bcla_skid_buf.sv
// Two-entry skid buffer (head + spill) whose ready output comes straight from a register.
module bcla_skid_buf
    import bcla_pkg::*;
#(
    parameter type T = op_pair_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic head_valid,
    output T     head,
    input  logic pop
);

    logic k_valid;
    T     k_data;
    logic push;

    assign push = in_valid & in_ready;

    // The spill slot only fills when the head is occupied and not leaving; ready tracks its emptiness.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_valid <= 1'b0;
            k_valid    <= 1'b0;
            in_ready   <= 1'b1;
        end else if (pop) begin
            if (k_valid) begin
                head    <= k_data;
                k_valid <= 1'b0;
            end else begin
                head_valid <= push;
                if (push) begin
                    head <= in_data;
                end
            end
            in_ready <= 1'b1;
        end else if (push) begin
            if (!head_valid) begin
                head_valid <= 1'b1;
                head       <= in_data;
                in_ready   <= 1'b1;
            end else begin
                k_valid  <= 1'b1;
                k_data   <= in_data;
                in_ready <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bcla14_pipe_stage.sv
// Registered, valid/ready wrapper around the BCLA adder: skid buffer in, one output register out.
// Optional transfer/overflow counters are enabled by defining BCLA_PIPE_PERF_CNT_EN.
module bcla14_pipe_stage
    import bcla_pkg::*;
#(
    parameter int         W       = BCLA_W,
    parameter logic [W:0] SUM_RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    input  logic         in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   out_sum
`ifdef BCLA_PIPE_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_cnt,
    output logic [PERF_CNT_W-1:0] ovf_cnt
`endif
);

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         cin;
    } pair_t;

    pair_t      in_pair;
    pair_t      head;
    logic       head_valid;
    logic       load;
    logic [W:0] sum;

    assign in_pair = '{x: in_x, y: in_y, cin: in_cin};
    assign load    = head_valid & (~out_valid | out_ready);

    bcla_skid_buf #(.T(pair_t)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_pair),
        .head_valid (head_valid),
        .head       (head),
        .pop        (load)
    );

    if (W == BCLA_W) begin : g_bcla
        assign sum = bcla14_add(head.x, head.y, head.cin);
    end else begin : g_generic
        assign sum = {1'b0, head.x} + {1'b0, head.y} + {{W{1'b0}}, head.cin};
    end

    // out_sum keeps its last value when out_valid drops; only a load changes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= SUM_RST;
        end else if (load) begin
            out_valid <= 1'b1;
            out_sum   <= sum;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef BCLA_PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cnt <= '0;
            ovf_cnt  <= '0;
        end else if (out_valid && out_ready) begin
            perf_cnt <= perf_cnt + PERF_CNT_W'(1);
            if (out_sum[W]) begin
                ovf_cnt <= ovf_cnt + PERF_CNT_W'(1);
            end
        end
    end
`else
    // No counter state in this build.
`endif

endmodule

// File: tb/tb_bcla14_pipe_stage.sv
// Self-checking bench for bcla14_pipe_stage: FIFO sum model plus directed literal checks.
module tb_bcla14_pipe_stage;

    localparam int W = 14;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_sum;
`ifdef BCLA_PIPE_PERF_CNT_EN
    logic [15:0]  perf_cnt;
    logic [15:0]  ovf_cnt;
`endif

    int checks;
    int fails;
    int outXfers;
    logic [W:0] expQ[$];

    bcla14_pipe_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
`ifdef BCLA_PIPE_PERF_CNT_EN
        ,
        .perf_cnt  (perf_cnt),
        .ovf_cnt   (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] modelSum(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int s;
        s = int'(x) + int'(y) + int'(c);
        return s[W:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        in_valid = v;
        in_x     = x;
        in_y     = y;
        in_cin   = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1ns after rising edges, so the falling edge shows what the next rising edge will use.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
        end else begin
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_output: got 0x%0h expected no valid output at %0t", out_sum, $time);
                end else begin
                    checkOutput("model_sum", 32'(out_sum), 32'(expQ[0]));
                    if (out_ready) begin
                        void'(expQ.pop_front());
                        outXfers++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                expQ.push_back(modelSum(in_x, in_y, in_cin));
            end
        end
    end

    initial begin
        int base;
        checks    = 0;
        fails     = 0;
        outXfers  = 0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b1, 14'h0123, 14'h0456, 1'b0);

        tick();
        tick();
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_sum", 32'(out_sum), 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 14'h0, 14'h0, 1'b0);
        tick();
        checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("post_reset_xfers", 32'(outXfers), 32'd0);

        applyStimulus(1'b1, 14'h3FFF, 14'h0001, 1'b0);
        tick();
        applyStimulus(1'b0, 14'h0, 14'h0, 1'b0);
        checkOutput("single_latency_n", 32'(out_valid), 32'd0);
        tick();
        checkOutput("single_valid", 32'(out_valid), 32'd1);
        checkOutput("single_sum", 32'(out_sum), 32'h4000);
        tick();
        checkOutput("single_drain", 32'(out_valid), 32'd0);

        applyStimulus(1'b1, 14'h3FFF, 14'h3FFF, 1'b1);
        tick();
        applyStimulus(1'b0, 14'h0, 14'h0, 1'b0);
        tick();
        checkOutput("max_valid", 32'(out_valid), 32'd1);
        checkOutput("max_sum", 32'(out_sum), 32'h7FFF);
        tick();

        base = outXfers;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)),
                          1'($urandom_range(0, 1)));
            tick();
            checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
        end
        applyStimulus(1'b0, 14'h0, 14'h0, 1'b0);
        tick();
        tick();
        checkOutput("stream_no_bubbles", 32'(outXfers - base), 32'd100);
        tick();
        checkOutput("stream_drained", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        applyStimulus(1'b1, 14'd1, 14'd2, 1'b0);
        tick();
        applyStimulus(1'b1, 14'd3, 14'd4, 1'b0);
        tick();
        checkOutput("bp_ready_after_2", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 14'd5, 14'd6, 1'b0);
        tick();
        checkOutput("bp_ready_after_3", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 14'd7, 14'd8, 1'b0);
        tick();
        checkOutput("bp_stall_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_hold_sum", 32'(out_sum), 32'd3);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_out_7", 32'(out_sum), 32'd7);
        tick();
        checkOutput("bp_out_11", 32'(out_sum), 32'd11);
        applyStimulus(1'b0, 14'h0, 14'h0, 1'b0);
        tick();
        checkOutput("bp_out_15", 32'(out_sum), 32'd15);
        checkOutput("bp_out_15_valid", 32'(out_valid), 32'd1);
        tick();
        checkOutput("bp_empty", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        applyStimulus(1'b1, 14'd100, 14'd200, 1'b0);
        tick();
        applyStimulus(1'b1, 14'd300, 14'd400, 1'b0);
        tick();
        applyStimulus(1'b1, 14'd500, 14'd600, 1'b1);
        tick();
        applyStimulus(1'b0, 14'h0, 14'h0, 1'b0);
        checkOutput("flush_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("flush_no_old_sum", 32'(out_valid), 32'd0);
        end

`ifdef BCLA_PIPE_PERF_CNT_EN
        for (int i = 0; i < 65537; i++) begin
            if (i == 10 || i == 20) applyStimulus(1'b1, 14'h2000, 14'h2000, 1'b0);
            else applyStimulus(1'b1, 14'd1, 14'd1, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 14'h0, 14'h0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("perf_cnt_wrap", 32'(perf_cnt), 32'd1);
        checkOutput("ovf_cnt", 32'(ovf_cnt), 32'd2);
`endif

        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bcla14_pipe_stage.md
Name: bcla14_pipe_stage

Overview:
- Registered, flow-controlled wrapper around the 14-bit block carry look-ahead adder.
- Accepts operand pairs from upstream through a 2-entry skid buffer.
- Forms the W+1-bit sum combinationally from the buffer head and drives it through one output register with valid/ready handshakes.
- Sits between the operand-producing datapath and any sum consumer. It isolates the adder's combinational carry chain from both neighbours' timing.

Parameters:
- W, 14, operand width; sum width is W+1; legal W ≥ 2.
- SUM_RST, 0, reset value of out_sum (W+1 bits).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low; sampled only on rising clk.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  stage can accept; driven directly from a register (no combinational path from out_ready).
- in_x  in  W  operand X.
- in_y  in  W  operand Y.
- in_cin  in  1  carry-in; tie 0 for plain unsigned add.
- out_valid  out  1  out_sum holds a valid result.
- out_ready  in  1  downstream accepts.
- out_sum  out  W+1  {carry_out, sum[W-1:0]} = in_x + in_y + in_cin.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - in_ready=1 is visible after the edge; out_valid=0; out_sum=SUM_RST.
  - Skid buffer emptied; any in-flight data is discarded.
  - Handshakes during a reset cycle are ignored.
- Input transfer occurs on an edge with in_valid & in_ready; output transfer occurs on an edge with out_valid & out_ready.
- Skid buffer:
  - Two entries, head (H) and spill (K).
  - Push goes to H if H is empty or H is popped in the same cycle; otherwise it goes to K.
  - On pop, K moves to H.
  - in_ready_next = !(K full after this edge).
  - Simultaneous push and pop with one entry held: occupancy stays 1 and the new data lands in H.
- Adder: sum = zero-extended H.x + H.y + H.cin, computed combinationally over the full W+1 bits with no truncation.
  - Max case: x=y=2^W-1, cin=1 gives 2^(W+1)-1.
- Output register:
  - Loads sum and sets out_valid=1 when H is valid and (out_valid=0 or out_ready=1). That same edge pops H.
  - Clears out_valid when out_ready=1 and no new load occurs.
  - out_sum holds its value while out_valid=1 and out_ready=0. Its value is unchanged (not cleared) when out_valid drops.
- Latency: an input transfer at edge N makes the result visible with out_valid=1 after edge N+1, provided the output register was free.
- Throughput: 1 result/cycle with out_ready held 1; no bubbles.
- Backpressure: with out_ready=0 the stage absorbs up to 3 pairs (output register + H + K). in_ready deasserts after the edge that fills K.
- Order is strictly FIFO; no data is dropped or duplicated.
- Reset mid-operation is flush-only; no partial results are emitted afterwards.

Optional Feature:
- Macro: BCLA_PIPE_PERF_CNT_EN.
- Defined:
  - Adds output port perf_cnt, 16 bits: count of output transfers.
  - Resets to 0; increments by 1 on each output transfer; wraps 0xFFFF→0x0000.
  - Adds output port ovf_cnt, 16 bits: count of output transfers whose out_sum[W]=1, with the same wrap rule.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package bcla_pkg:
  - Constant BCLA_W=14.
  - typedef operand_t (W bits).
  - typedef sum_t (W+1 bits).
  - typedef struct op_pair_t {x, y, cin}.
  - Constant PERF_CNT_W=16.
- One natural sub-module: bcla_skid_buf, the 2-entry registered-ready buffer carrying op_pair_t.
- The adder is instantiated as the existing 14-bit BCLA core for W=14, or a generic +, selected by generate.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1 → in_ready=1, out_valid=0, out_sum=0 after release; no output transfer.
- Single op: x=0x3FFF, y=0x0001, cin=0 accepted at edge N → after N+1: out_valid=1, out_sum=0x4000. Then x=y=0x3FFF, cin=1 → 0x7FFF.
- Streaming: 100 random pairs with in_valid and out_ready held 1 → one result per cycle after the 1-edge fill; sums match the model in order.
- Backpressure: out_ready=0, push 4 pairs (1,2), (3,4), (5,6), (7,8) → in_ready=0 after 3rd accept; 4th stalls. out_ready=1 → outputs 3, 7, 11, 15 on consecutive cycles.
- Mid-flight reset: 3 entries held, assert rst_n=0 for one edge → out_valid=0, buffer empty; the old sums never appear afterwards.
- With BCLA_PIPE_PERF_CNT_EN: 65537 transfers, 2 of them with x=y=0x2000 → perf_cnt=1, ovf_cnt=2.
